// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, test-pattern encoding
// and pixel type. Also consumed by pixel_receiver.
package vga_pkg;
  localparam int VGA_WIDTH  = 640;
  localparam int VGA_HEIGHT = 480;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int H_TOTAL      = VGA_WIDTH + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL      = VGA_HEIGHT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int H_SYNC_START = VGA_WIDTH + VGA_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC;
  localparam int V_SYNC_START = VGA_HEIGHT + VGA_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC;

  localparam int CNT_BITS   = 10;
  localparam int PIXEL_BITS = 12;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    GRID     = 2'd0,
    SOLID    = 2'd1,
    BARS     = 2'd2,
    GRADIENT = 2'd3
  } pattern_e;

  // Bar index bits select full-on R, G, B nibbles: 0 = black, 7 = white.
  function automatic pixel_t bar_color(logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel-tick divider, h/v counters and combinational
// active / sync / frame-origin decode of the current counter position.
module vga_timing_gen #(
  parameter int WIDTH       = vga_pkg::VGA_WIDTH,
  parameter int HEIGHT      = vga_pkg::VGA_HEIGHT,
  parameter int H_FP        = vga_pkg::VGA_H_FP,
  parameter int H_SYNC      = vga_pkg::VGA_H_SYNC,
  parameter int H_BP        = vga_pkg::VGA_H_BP,
  parameter int V_FP        = vga_pkg::VGA_V_FP,
  parameter int V_SYNC      = vga_pkg::VGA_V_SYNC,
  parameter int V_BP        = vga_pkg::VGA_V_BP,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int CLK_DIV     = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [WIDTH_BITS-1:0]  x_o,
  output logic [HEIGHT_BITS-1:0] y_o,
  output logic                   active_o,
  output logic                   hsync_n_o,
  output logic                   vsync_n_o,
  output logic                   tick_o,
  output logic                   origin_o,
  output logic                   first_o
);
  import vga_pkg::*;

  localparam int HT          = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int VT          = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam bit TOTALS_FIT  = (HT <= (1 << CNT_BITS)) && (VT <= (1 << CNT_BITS));

  generate
    if (!TOTALS_FIT) begin : g_totals_too_big
      $error("vga_timing_gen: line/frame totals exceed counter width");
    end
  endgenerate

  localparam logic [CNT_BITS-1:0] H_LAST   = CNT_BITS'(HT - 1);
  localparam logic [CNT_BITS-1:0] V_LAST   = CNT_BITS'(VT - 1);
  localparam logic [CNT_BITS-1:0] H_ACT    = CNT_BITS'(WIDTH);
  localparam logic [CNT_BITS-1:0] V_ACT    = CNT_BITS'(HEIGHT);
  localparam logic [CNT_BITS-1:0] HS_START = CNT_BITS'(WIDTH + H_FP);
  localparam logic [CNT_BITS-1:0] HS_END   = CNT_BITS'(WIDTH + H_FP + H_SYNC);
  localparam logic [CNT_BITS-1:0] VS_START = CNT_BITS'(HEIGHT + V_FP);
  localparam logic [CNT_BITS-1:0] VS_END   = CNT_BITS'(HEIGHT + V_FP + V_SYNC);

  localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [CNT_BITS-1:0] h_q, h_d, v_q, v_d;
  logic                tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign x_o       = h_q[WIDTH_BITS-1:0];
  assign y_o       = v_q[HEIGHT_BITS-1:0];
  assign active_o  = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_n_o = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync_n_o = !((v_q >= VS_START) && (v_q < VS_END));
  assign tick_o    = tick;
  assign origin_o  = (h_q == '0) && (v_q == '0);
  // First of the CLK_DIV clocks spent at a position.
  assign first_o   = (div_q == '0);
endmodule

// File: rtl/vga_pixel_transmitter.sv
// VGA source: raster timing plus a selectable test pattern, all outputs
// registered once so they line up with the same counter position.
module vga_pixel_transmitter #(
  parameter int WIDTH       = vga_pkg::VGA_WIDTH,
  parameter int HEIGHT      = vga_pkg::VGA_HEIGHT,
  parameter int H_FP        = vga_pkg::VGA_H_FP,
  parameter int H_SYNC      = vga_pkg::VGA_H_SYNC,
  parameter int H_BP        = vga_pkg::VGA_H_BP,
  parameter int V_FP        = vga_pkg::VGA_V_FP,
  parameter int V_SYNC      = vga_pkg::VGA_V_SYNC,
  parameter int V_BP        = vga_pkg::VGA_V_BP,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int PIXEL_BITS  = 12,
  parameter int CLK_DIV     = 1
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic [1:0]             pattern_sel_in,
  input  logic [PIXEL_BITS-1:0]  color_in,
  output logic [WIDTH_BITS-1:0]  pixel_x_out,
  output logic [HEIGHT_BITS-1:0] pixel_y_out,
  output logic [PIXEL_BITS-1:0]  pixel_out,
  output logic                   video_on_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   frame_start_out
);
  import vga_pkg::*;

  localparam logic [WIDTH_BITS-1:0]  BAR_W  = WIDTH_BITS'(WIDTH / 8);
  localparam logic [WIDTH_BITS-1:0]  X_MID  = WIDTH_BITS'(WIDTH / 2);
  localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(WIDTH - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_MID  = HEIGHT_BITS'(HEIGHT / 2);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(HEIGHT - 1);

  logic [WIDTH_BITS-1:0]  x;
  logic [HEIGHT_BITS-1:0] y;
  logic                   active, hs_n, vs_n, tick, origin, first;

  vga_timing_gen #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .WIDTH_BITS(WIDTH_BITS), .HEIGHT_BITS(HEIGHT_BITS), .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk_i(clock_in), .rst_ni(reset_n_in),
    .x_o(x), .y_o(y), .active_o(active),
    .hsync_n_o(hs_n), .vsync_n_o(vs_n),
    .tick_o(tick), .origin_o(origin), .first_o(first)
  );

  pattern_e              pat_q, pat;
  logic [PIXEL_BITS-1:0] color_q, color;

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      pat_q   <= GRID;
      color_q <= '0;
    end else if (origin && tick) begin
      pat_q   <= pattern_e'(pattern_sel_in);
      color_q <= color_in;
    end
  end

  // At the origin the latch is only just being loaded, so use the live inputs
  // there; the whole frame then sees the same selection.
  assign pat   = origin ? pattern_e'(pattern_sel_in) : pat_q;
  assign color = origin ? color_in : color_q;

  logic [2:0]            bar;
  logic [PIXEL_BITS-1:0] pix_d;

  always_comb begin
    bar   = 3'(x / BAR_W);
    pix_d = '0;
    if (active) begin
      case (pat)
        GRID:     if (x == '0 || x == X_MID || x == X_LAST ||
                      y == '0 || y == Y_MID || y == Y_LAST) pix_d = '1;
        SOLID:    pix_d = color;
        BARS:     pix_d = bar_color(bar);
        GRADIENT: pix_d = {x[WIDTH_BITS-1 -: 4], y[HEIGHT_BITS-1 -: 4], 4'h0};
        default:  pix_d = '0;
      endcase
    end
  end

  logic [WIDTH_BITS-1:0]  x_q;
  logic [HEIGHT_BITS-1:0] y_q;
  logic [PIXEL_BITS-1:0]  pix_q;
  logic                   von_q, hs_q, vs_q, fs_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      x_q   <= '0;
      y_q   <= '0;
      pix_q <= '0;
      von_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= active ? x : '0;
      y_q   <= active ? y : '0;
      pix_q <= pix_d;
      von_q <= active;
      hs_q  <= hs_n;
      vs_q  <= vs_n;
      fs_q  <= origin && first;
    end
  end

  assign pixel_x_out     = x_q;
  assign pixel_y_out     = y_q;
  assign pixel_out       = pix_q;
  assign video_on_out    = von_q;
  assign h_sync_out      = hs_q;
  assign v_sync_out      = vs_q;
  assign frame_start_out = fs_q;
endmodule

// File: doc/vga_pixel_transmitter.md
Name: vga_pixel_transmitter

Overview:
- Source end of the pixel interface that pixel_receiver consumes.
- Generates 640x480@60 VGA raster timing: horizontal/vertical counters, active-low syncs, video_on, pixel coordinates.
- Drives a 12-bit pixel from a selectable built-in test pattern.
- Sits between the pixel-clock domain and pixel_receiver / DAC pins; used as the synthesizable stimulus source replacing bench-driven loops.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
WIDTH_BITS, 10, pixel_x width
HEIGHT_BITS, 9, pixel_y width
PIXEL_BITS, 12, pixel width (RGB 4:4:4)
CLK_DIV, 1, clocks per pixel tick (1 = every clock)

Ports:
clock_in  input  1  pixel/system clock
reset_n_in  input  1  synchronous active-low reset
pattern_sel_in  input  2  0 grid, 1 solid, 2 colour bars, 3 gradient
color_in  input  PIXEL_BITS  colour for solid pattern
pixel_x_out  output  WIDTH_BITS  current x (0 outside active)
pixel_y_out  output  HEIGHT_BITS  current y (0 outside active)
pixel_out  output  PIXEL_BITS  pixel value (0 outside active)
video_on_out  output  1  high in active region
h_sync_out  output  1  active-low horizontal sync
v_sync_out  output  1  active-low vertical sync
frame_start_out  output  1  one-clock pulse with first pixel of a frame

Behaviour:
- Clock and reset: one clock, clock_in. Reset is synchronous and active-low on reset_n_in.
- Reset state: h_count=0, v_count=0, tick divider=0, latched pattern=0.
- Outputs during reset:
  - pixel_x_out=0, pixel_y_out=0, pixel_out=0
  - video_on_out=0, frame_start_out=0
  - h_sync_out=1, v_sync_out=1
- Counters:
  - H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP = 525.
  - Counters are 10 bits; a localparam checks that the totals fit.
- Tick: a divider counts 0..CLK_DIV-1; tick=1 when the divider is at CLK_DIV-1. With CLK_DIV=1, tick is always 1.
- On tick:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps to 0 at V_TOTAL-1 when h_count wraps.
- Decode, from the counters, combinational:
  - active = h<WIDTH and v<HEIGHT
  - hsync_n = 0 for WIDTH+H_FP <= h < WIDTH+H_FP+H_SYNC (656..751)
  - vsync_n = 0 for HEIGHT+V_FP <= v < HEIGHT+V_FP+V_SYNC (490..491)
- Output stage: one register stage updated every clock.
  - All outputs are aligned to the same counter position.
  - Latency is 1 clock from counter state to outputs.
  - With CLK_DIV>1, each position is held for CLK_DIV clocks.
  - frame_start_out is high only on the first clock presenting (0,0).
- Coordinates: pixel_x_out=h[WIDTH_BITS-1:0] and pixel_y_out=v[HEIGHT_BITS-1:0] when active; otherwise both 0.
- Pattern latching: pattern_sel_in and color_in are latched when counters are at (0,0) on a tick, i.e. at a frame boundary. Changes mid-frame take effect the next frame.
- The first frame after reset uses the value latched at (0,0), which is the live input at the first tick.
- Patterns (active only; otherwise pixel_out=0):
  - 0 grid: all-ones when x in {0, WIDTH/2, WIDTH-1} or y in {0, HEIGHT/2, HEIGHT-1}; else 0.
  - 1 solid: latched color.
  - 2 bars: bar = x / (WIDTH/8), 8 bars. pixel = {R,G,B} nibbles each 4'hF or 0 from bar bits [2],[1],[0]; bar 0 = black, bar 7 = white.
  - 3 gradient: R = x[WIDTH_BITS-1 -: 4], G = y[HEIGHT_BITS-1 -: 4], B = 4'h0.
- Reset mid-frame: counters return to (0,0) on the reset edge. Outputs take reset values while reset_n_in=0. The first post-reset frame starts clean with frame_start_out.

Decomposition:
- Package vga_pkg: timing localparams (H_TOTAL, V_TOTAL, sync start/end), pattern_e enum (GRID, SOLID, BARS, GRADIENT), and a pixel_t typedef of PIXEL_BITS. The package is shared with pixel_receiver.
- One sub-module, vga_timing_gen: divider, counters, active/sync decode.
- Pattern mux and output register stay in the top module.

Test Plan:
- Reset held 5 clocks, then released:
  - Outputs stay at reset values during reset.
  - 1 clock after release: video_on_out=1, pixel_x_out=0, pixel_y_out=0, frame_start_out=1.
- Line timing, CLK_DIV=1: video_on_out high for 640 consecutive clocks per line; h_sync_out low for exactly 96 clocks starting 16 clocks after video_on falls; line period 800 clocks.
- Frame timing:
  - v_sync_out low for 2 lines (1600 clocks) starting at line 490.
  - frame_start_out period 420000 clocks.
  - 480 lines with video_on_out.
- Grid pattern, pattern_sel_in=0: pixel_out=12'hFFF at (0,5), (320,100), (639,7), (5,240), (10,479); 12'h000 at (1,1); 0 whenever video_on_out=0.
- Pattern switch mid-frame: pattern_sel_in 0->1 with color_in=12'h0F0 at line 100:
  - Grid continues to frame end.
  - Next frame pixel_out=12'h0F0 at every active pixel.
  - Bars check with pattern 2: x=0 gives 12'h000, x=80 gives 12'h00F, x=639 gives 12'hFFF.
- Reset mid-frame at (300,200), plus CLK_DIV=2 run:
  - Restart at (0,0) with frame_start_out pulse.
  - With CLK_DIV=2, each coordinate is held 2 clocks and the line period is 1600 clocks.
